viterbi_traceback: RTL and testbench
====================================

Name: viterbi_traceback

Overview:
- Survivor-path memory and traceback stage of the 4-state (K=3, rate 1/2) Viterbi decoder; sits directly downstream of the add-compare-select stage.
- Stores one 4-entry survivor vector (predecessor state per current state) per trellis step for a frame of TB_LEN steps.
- At frame end, traces back from the best end node supplied by ACS and emits the decoded bits serially, in original time order.

Parameters:
TB_LEN, 8, trellis steps per frame (survivor memory depth); must be >= 2.
AW, 3, pointer width; 2^AW >= TB_LEN required.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
i_valid  input  1  survivor vector valid this cycle (driven by ACS enable).
i_prv_st_00  input  2  predecessor of state 00 at this step.
i_prv_st_10  input  2  predecessor of state 10.
i_prv_st_01  input  2  predecessor of state 01.
i_prv_st_11  input  2  predecessor of state 11.
i_start_node  input  2  best final state; sampled only in LATCH.
o_bit  output  1  decoded bit.
o_bit_valid  output  1  o_bit qualifier.
o_last  output  1  high with the final bit of a frame.
o_busy  output  1  high when state != WRITE; i_valid is not accepted.
o_overrun  output  1  sticky; set when i_valid is high while o_busy is high.

Behaviour:
- Reset (rst=0, async):
  - State=WRITE; wr_ptr=0, tb_ptr=0, out_ptr=0, cur_state=00.
  - o_bit, o_bit_valid, o_last, o_overrun all 0.
  - Memory and bit buffer contents are don't-care.
  - Reset mid-frame or mid-output aborts the frame; no further outputs until a new frame is written.
- Trellis convention:
  - Next state = {input_bit, old_state[1]}.
  - Decoded bit for step t = state_t[1].
  - Memory word index order: 00, 10, 01, 11.
- FSM states: WRITE, LATCH, TRACE, OUTPUT.
- WRITE:
  - On each edge with i_valid=1: mem[wr_ptr] <= {the four i_prv_st values}; wr_ptr increments.
  - On the write with wr_ptr==TB_LEN-1: wr_ptr <= 0 and go to LATCH.
  - i_valid=0 holds state and pointer.
- LATCH (1 cycle):
  - cur_state <= i_start_node; tb_ptr <= TB_LEN-1; go to TRACE.
  - This matches the 1-cycle registered select-node latency of ACS.
- TRACE (exactly TB_LEN cycles), per edge:
  - bitbuf[tb_ptr] <= cur_state[1]
  - cur_state <= mem[tb_ptr][cur_state]
  - tb_ptr decrements
  - After the tb_ptr==0 step, go to OUTPUT with out_ptr=0.
- OUTPUT (TB_LEN cycles), per edge:
  - o_bit <= bitbuf[out_ptr]; o_bit_valid <= 1; out_ptr increments.
  - o_last <= 1 when out_ptr==TB_LEN-1.
  - On that same edge, state returns to WRITE.
  - The next edge clears o_bit_valid/o_last unless another frame is already outputting (cannot happen).
- Outputs are registered. o_bit holds its last value when o_bit_valid=0.
- Latency: last write at edge E, then LATCH at E+1, then TRACE at E+2..E+TB_LEN+1. o_bit_valid is high after edges E+TB_LEN+2..E+2*TB_LEN+1.
- o_busy is decoded from the state register (combinational). It is low in the cycle after the edge that registers o_last, so a new frame's first vector is accepted at the next edge.
- i_valid while o_busy=1 is dropped (memory and pointers unchanged) and sets o_overrun; only reset clears it.
- Memory reads are combinational from registers (TB_LEN x 8-bit array); no RAM inference required.

Test Plan:
- Reset: apply rst=0 mid-OUTPUT → o_bit_valid, o_last, o_overrun go 0 immediately. After release, o_busy=0 and no output until 8 new vectors are written.
- All-zero frame: 8 vectors all predecessors 00, i_start_node=00 → 8 bits 0; o_last on the 8th; first o_bit_valid 10 edges after the last write.
- Path frame (TB_LEN=8), all other fields 0:
  - t0: prv_st_10=00
  - t1: prv_st_01=10
  - t2: prv_st_00=01
  - t3..t7: prv_st_00=00
  - i_start_node=00
  - → output 1,0,0,0,0,0,0,0.
- Start-node sampling: same frame, i_start_node=11 during LATCH, 00 at every other cycle, all predecessors 11 → output 1,1,1,1,1,1,1,1 (proves LATCH-only sampling).
- Gapped input: 8 vectors with i_valid toggling 1/0 → identical output to the contiguous case.
- Overrun: i_valid=1 continuously through TRACE/OUTPUT → o_overrun=1 sticky, current frame output unchanged, next frame starts at the first i_valid after o_busy falls.

Source files
------------

// File: rtl/viterbi_traceback.sv
// Survivor-path memory and traceback for the 4-state (K=3, rate 1/2) Viterbi
// decoder. One 8-bit survivor vector per trellis step is stored. At frame end
// the path is traced back from the best end node and the decoded bits are
// replayed serially in original time order.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_WRITE  | accept survivor vectors into memory, one per i_valid
// ST_LATCH  | capture best end node from ACS, arm traceback pointer
// ST_TRACE  | walk predecessors from step TB_LEN-1 down to 0, store bits
// ST_OUTPUT | emit stored bits oldest-first, o_last on the final one
module viterbi_traceback #(
    parameter int TB_LEN = 8,
    parameter int AW     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [1:0] i_prv_st_00,
    input  logic [1:0] i_prv_st_10,
    input  logic [1:0] i_prv_st_01,
    input  logic [1:0] i_prv_st_11,
    input  logic [1:0] i_start_node,
    output logic       o_bit,
    output logic       o_bit_valid,
    output logic       o_last,
    output logic       o_busy,
    output logic       o_overrun
);

    typedef enum logic [1:0] {
        ST_WRITE  = 2'd0,
        ST_LATCH  = 2'd1,
        ST_TRACE  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(TB_LEN - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     tb_ptr_q, tb_ptr_d;
    logic [AW-1:0]     out_ptr_q, out_ptr_d;
    logic [1:0]        cur_state_q, cur_state_d;
    logic [7:0]        mem_q [TB_LEN];
    logic [7:0]        mem_d [TB_LEN];
    logic [TB_LEN-1:0] bitbuf_q, bitbuf_d;
    logic              o_bit_q, o_bit_d;
    logic              o_bit_valid_q, o_bit_valid_d;
    logic              o_last_q, o_last_d;
    logic              o_overrun_q, o_overrun_d;

    logic [7:0]        rd_word;
    logic [1:0]        rd_slot;
    logic [1:0]        prv_sel;

    // Predecessor lookup: words are packed 00,10,01,11 from the LSB, so the
    // slot of a state is its two bits swapped.
    always_comb begin
        rd_word = mem_q[tb_ptr_q];
        rd_slot = {cur_state_q[0], cur_state_q[1]};
        prv_sel = rd_word[{rd_slot, 1'b0} +: 2];
    end

    // Next-state and datapath computation for the whole controller.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        tb_ptr_d      = tb_ptr_q;
        out_ptr_d     = out_ptr_q;
        cur_state_d   = cur_state_q;
        mem_d         = mem_q;
        bitbuf_d      = bitbuf_q;
        o_bit_d       = o_bit_q;
        o_bit_valid_d = 1'b0;
        o_last_d      = 1'b0;
        // Vectors arriving while busy are dropped; remember it until reset.
        o_overrun_d   = o_overrun_q | (i_valid && (state_q != ST_WRITE));

        case (state_q)
            ST_WRITE: begin
                if (i_valid) begin
                    mem_d[wr_ptr_q] = {i_prv_st_11, i_prv_st_01, i_prv_st_10, i_prv_st_00};
                    if (wr_ptr_q == LAST_IDX) begin
                        wr_ptr_d = '0;
                        state_d  = ST_LATCH;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                // ACS presents its registered best node one cycle after the last vector.
                cur_state_d = i_start_node;
                tb_ptr_d    = LAST_IDX;
                state_d     = ST_TRACE;
            end
            ST_TRACE: begin
                bitbuf_d[tb_ptr_q] = cur_state_q[1];
                cur_state_d        = prv_sel;
                tb_ptr_d           = tb_ptr_q - 1'b1;
                if (tb_ptr_q == '0) begin
                    out_ptr_d = '0;
                    state_d   = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                o_bit_d       = bitbuf_q[out_ptr_q];
                o_bit_valid_d = 1'b1;
                out_ptr_d     = out_ptr_q + 1'b1;
                if (out_ptr_q == LAST_IDX) begin
                    o_last_d  = 1'b1;
                    out_ptr_d = '0;
                    state_d   = ST_WRITE;
                end
            end
            default: state_d = ST_WRITE;
        endcase
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_WRITE;
            wr_ptr_q      <= '0;
            tb_ptr_q      <= '0;
            out_ptr_q     <= '0;
            cur_state_q   <= 2'b00;
            o_bit_q       <= 1'b0;
            o_bit_valid_q <= 1'b0;
            o_last_q      <= 1'b0;
            o_overrun_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            tb_ptr_q      <= tb_ptr_d;
            out_ptr_q     <= out_ptr_d;
            cur_state_q   <= cur_state_d;
            o_bit_q       <= o_bit_d;
            o_bit_valid_q <= o_bit_valid_d;
            o_last_q      <= o_last_d;
            o_overrun_q   <= o_overrun_d;
        end
    end

    // Survivor memory and bit buffer; contents are meaningless until written.
    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        bitbuf_q <= bitbuf_d;
    end

    assign o_bit       = o_bit_q;
    assign o_bit_valid = o_bit_valid_q;
    assign o_last      = o_last_q;
    assign o_overrun   = o_overrun_q;
    assign o_busy      = (state_q != ST_WRITE);

endmodule

// File: tb/tb_viterbi_traceback.sv
// Bench for viterbi_traceback: directed frames with literal expectations plus
// a randomized phase, all checked every cycle against a timeline-based model.
module tb_viterbi_traceback;

    localparam int TB_LEN = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid = 1'b0;
    logic [1:0] i_prv_st_00 = '0;
    logic [1:0] i_prv_st_10 = '0;
    logic [1:0] i_prv_st_01 = '0;
    logic [1:0] i_prv_st_11 = '0;
    logic [1:0] i_start_node = '0;
    logic       o_bit, o_bit_valid, o_last, o_busy, o_overrun;

    viterbi_traceback #(.TB_LEN(TB_LEN), .AW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_prv_st_00  (i_prv_st_00),
        .i_prv_st_10  (i_prv_st_10),
        .i_prv_st_01  (i_prv_st_01),
        .i_prv_st_11  (i_prv_st_11),
        .i_start_node (i_start_node),
        .o_bit        (o_bit),
        .o_bit_valid  (o_bit_valid),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Predecessors stored per step indexed by the state's numeric value.
    logic [1:0]        mp [TB_LEN][4];
    logic [TB_LEN-1:0] mbits = '0;
    logic [1:0]        m_s;
    int                n = 0;
    int                e_edge = 0;
    bit                have = 0;
    int                wcnt = 0;
    logic              exp_valid = 0, exp_bit = 0, exp_last = 0, exp_busy = 0, exp_ovr = 0;

    // Busy holds from the last-write edge E through edge E+2*TB_LEN.
    function automatic bit busy_after(input int m);
        return have && (m >= e_edge) && (m <= e_edge + 2 * TB_LEN);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            have = 0; wcnt = 0;
            exp_valid = 0; exp_bit = 0; exp_last = 0; exp_busy = 0; exp_ovr = 0;
        end else begin
            n++;
            if (i_valid) begin
                if (busy_after(n - 1)) exp_ovr = 1;
                else begin
                    mp[wcnt][0] = i_prv_st_00;
                    mp[wcnt][2] = i_prv_st_10;
                    mp[wcnt][1] = i_prv_st_01;
                    mp[wcnt][3] = i_prv_st_11;
                    if (wcnt == TB_LEN - 1) begin
                        wcnt = 0; e_edge = n; have = 1;
                    end else wcnt++;
                end
            end
            if (have && n == e_edge + 1) begin
                m_s = i_start_node;
                for (int t = TB_LEN - 1; t >= 0; t--) begin
                    mbits[t] = m_s[1];
                    m_s = mp[t][m_s];
                end
            end
            if (have && n >= e_edge + TB_LEN + 2 && n <= e_edge + 2 * TB_LEN + 1) begin
                exp_valid = 1;
                exp_bit   = mbits[n - e_edge - TB_LEN - 2];
                exp_last  = (n == e_edge + 2 * TB_LEN + 1);
            end else begin
                exp_valid = 0;
                exp_last  = 0;
            end
            exp_busy = busy_after(n);
        end
    end

    // ---------------- per-cycle compare and capture ----------------
    logic [TB_LEN-1:0] cap = '0;
    int                cap_n = 0;
    bit                seen_last = 0;
    time               first_t = 0;
    time               t_last = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("o_bit_valid", o_bit_valid, exp_valid);
            chk("o_bit", o_bit, exp_bit);
            chk("o_last", o_last, exp_last);
            chk("o_busy", o_busy, exp_busy);
            chk("o_overrun", o_overrun, exp_ovr);
            if (o_bit_valid) begin
                if (cap_n == 0) first_t = $time;
                if (cap_n < TB_LEN) cap[cap_n] = o_bit;
                cap_n++;
                if (o_last) seen_last = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] fp [TB_LEN][4];

    task automatic fill_frame(input logic [1:0] v);
        for (int i = 0; i < TB_LEN; i++)
            for (int s = 0; s < 4; s++) fp[i][s] = v;
    endtask

    task automatic drive_rand();
        i_prv_st_00 = 2'($urandom);
        i_prv_st_10 = 2'($urandom);
        i_prv_st_01 = 2'($urandom);
        i_prv_st_11 = 2'($urandom);
    endtask

    task automatic send_frame(input logic [1:0] st, input bit latch_only, input bit gap, input bit ovr);
        cap = '0; cap_n = 0; seen_last = 0; first_t = 0;
        for (int i = 0; i < TB_LEN; i++) begin
            @(negedge clk);
            i_valid      = 1'b1;
            i_prv_st_00  = fp[i][0];
            i_prv_st_10  = fp[i][2];
            i_prv_st_01  = fp[i][1];
            i_prv_st_11  = fp[i][3];
            i_start_node = latch_only ? 2'b00 : st;
            if (i == TB_LEN - 1) t_last = $time;
            if (gap && i < TB_LEN - 1) begin
                @(negedge clk);
                i_valid = 1'b0;
                drive_rand();
            end
        end
        if (ovr) begin
            repeat (2 * TB_LEN + 1) begin
                @(negedge clk);
                i_valid = 1'b1;
                drive_rand();
            end
            @(negedge clk);
            i_valid = 1'b0;
        end else begin
            @(negedge clk);
            i_valid = 1'b0;
            if (latch_only) i_start_node = st;
            @(negedge clk);
            if (latch_only) i_start_node = 2'b00;
        end
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!seen_last && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk(name, 32'(seen_last), 32'd1);
    endtask

    task automatic set_path_frame();
        fill_frame(2'b00);
        fp[0][2] = 2'b00;   // predecessor of 10 at t0
        fp[1][1] = 2'b10;   // predecessor of 01 at t1
        fp[2][0] = 2'b01;   // predecessor of 00 at t2
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset o_bit_valid", 32'(o_bit_valid), 0);
        chk("reset o_last", 32'(o_last), 0);
        chk("reset o_overrun", 32'(o_overrun), 0);
        chk("reset o_busy", 32'(o_busy), 0);
        chk("reset o_bit", 32'(o_bit), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // all-zero frame, plus first-output latency
        fill_frame(2'b00);
        send_frame(2'b00, 0, 0, 0);
        wait_done("zero frame done");
        chk("zero frame bits", 32'(cap), 32'h00);
        chk("zero frame count", 32'(cap_n), TB_LEN);
        chk("zero frame latency", 32'(first_t - t_last), 32'd110);

        // single marked path
        set_path_frame();
        send_frame(2'b00, 0, 0, 0);
        wait_done("path frame done");
        chk("path frame bits", 32'(cap), 32'h01);
        chk("model path bits", 32'(mbits), 32'h01);

        // start node only honoured in the latch cycle
        fill_frame(2'b11);
        send_frame(2'b11, 1, 0, 0);
        wait_done("start node done");
        chk("start node bits", 32'(cap), 32'hFF);
        chk("model start node bits", 32'(mbits), 32'hFF);

        // gapped input gives the same result as contiguous
        set_path_frame();
        send_frame(2'b00, 0, 1, 0);
        wait_done("gapped frame done");
        chk("gapped frame bits", 32'(cap), 32'h01);
        chk("overrun still clear", 32'(o_overrun), 0);

        // continuous valid while busy
        set_path_frame();
        send_frame(2'b00, 0, 0, 1);
        wait_done("overrun frame done");
        chk("overrun frame bits", 32'(cap), 32'h01);
        chk("overrun sticky", 32'(o_overrun), 1);
        repeat (3) @(negedge clk);
        chk("overrun still sticky", 32'(o_overrun), 1);

        // reset in the middle of output
        set_path_frame();
        send_frame(2'b00, 0, 0, 0);
        begin
            int k = 0;
            while (!o_bit_valid && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("reached output before reset", 32'(o_bit_valid), 1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("async reset o_bit_valid", 32'(o_bit_valid), 0);
        chk("async reset o_last", 32'(o_last), 0);
        chk("async reset o_overrun", 32'(o_overrun), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("busy after reset release", 32'(o_busy), 0);
        cap_n = 0;
        repeat (20) @(negedge clk);
        chk("no output after reset", 32'(cap_n), 0);

        // randomized traffic, checked cycle by cycle against the model
        repeat (1500) begin
            @(negedge clk);
            i_valid      = ($urandom_range(0, 3) != 0);
            drive_rand();
            i_start_node = 2'($urandom);
        end
        @(negedge clk);
        i_valid = 1'b0;
        repeat (2 * TB_LEN + 6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
